// File: rtl/slave_port_arbiter_if.sv
// Master-side and slave-side handshake bundle for one crossbar slave port
// shared by M masters, plus arbiter status.
interface slave_port_arbiter_if #(
    parameter int N = 32,
    parameter int M = 2
);
    localparam int GW = $clog2(M);

    logic [M-1:0]   m_req;
    logic [M*N-1:0] m_addr;
    logic [M-1:0]   m_cmd;
    logic [M*N-1:0] m_wdata;
    logic [M-1:0]   m_ack;
    logic [M*N-1:0] m_rdata;
    logic           slave_req;
    logic [N-1:0]   slave_addr;
    logic           slave_cmd;
    logic [N-1:0]   slave_wdata;
    logic           slave_ack;
    logic [N-1:0]   slave_rdata;
    logic           busy;
    logic [GW-1:0]  grant_idx;

    // slave: the arbiter's own view (it serves the masters' requests)
    modport slave (
        input  m_req, m_addr, m_cmd, m_wdata, slave_ack, slave_rdata,
        output m_ack, m_rdata, slave_req, slave_addr, slave_cmd, slave_wdata,
               busy, grant_idx
    );

    // master: the environment side (masters plus the downstream slave)
    modport master (
        output m_req, m_addr, m_cmd, m_wdata, slave_ack, slave_rdata,
        input  m_ack, m_rdata, slave_req, slave_addr, slave_cmd, slave_wdata,
               busy, grant_idx
    );
endinterface

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter that locks one of M masters onto a single slave port
// until its transaction is acked (or the master aborts by dropping req).

module slave_port_arbiter_lane #(
    parameter int N = 32
) (
    input  logic         sel,
    input  logic         slave_ack,
    input  logic [N-1:0] slave_rdata,
    output logic         ack,
    output logic [N-1:0] rdata
);
    assign ack   = sel & slave_ack;
    assign rdata = sel ? slave_rdata : '0;
endmodule

module slave_port_arbiter #(
    parameter int N = 32,
    parameter int M = 2
) (
    input  logic               clk,
    input  logic               rst,
    slave_port_arbiter_if.slave bus
);
    localparam int GW = $clog2(M);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [GW-1:0]         grant_idx;
    logic [GW-1:0]         last;
    logic [GW-1:0]         pick;
    logic                  any_req;
    int                    idx;
    logic [M-1:0][N-1:0]   addr_v;
    logic [M-1:0][N-1:0]   wdata_v;
    logic [M-1:0][N-1:0]   rdata_v;
    logic [M-1:0]          ack_v;
    logic                  busy_st;

    assign addr_v  = bus.m_addr;
    assign wdata_v = bus.m_wdata;
    assign busy_st = (state == BUSY);

    // First requester strictly after the last-served master, wrapping mod M.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= M; k++) begin
            idx = (int'(last) + k) % M;
            if (!any_req && bus.m_req[GW'(idx)]) begin
                any_req = 1'b1;
                pick    = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last      <= GW'(M - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx <= pick;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion and abort (req dropped) both release the lock.
                    if (bus.slave_ack || !bus.m_req[grant_idx]) begin
                        last  <= grant_idx;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.slave_req   = busy_st & bus.m_req[grant_idx];
    assign bus.slave_addr  = busy_st ? addr_v[grant_idx]  : '0;
    assign bus.slave_cmd   = busy_st & bus.m_cmd[grant_idx];
    assign bus.slave_wdata = busy_st ? wdata_v[grant_idx] : '0;
    assign bus.busy        = busy_st;
    assign bus.grant_idx   = grant_idx;

    for (genvar i = 0; i < M; i++) begin : g_lane
        slave_port_arbiter_lane #(.N(N)) u_lane (
            .sel         (busy_st && (grant_idx == GW'(i))),
            .slave_ack   (bus.slave_ack),
            .slave_rdata (bus.slave_rdata),
            .ack         (ack_v[i]),
            .rdata       (rdata_v[i])
        );
    end

    assign bus.m_ack   = ack_v;
    assign bus.m_rdata = rdata_v;
endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-level owner/last model.
module tb_slave_port_arbiter;
    localparam int N = 32;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passes = 0;
    int   owner, last, gidx;
    logic [M-1:0] ack_prev;

    always #5 clk = ~clk;

    slave_port_arbiter_if #(.N(N), .M(M)) bus ();
    slave_port_arbiter #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        owner    = -1;
        last     = M - 1;
        gidx     = 0;
        ack_prev = '0;
    endtask

    task automatic clear_inputs();
        bus.m_req       = '0;
        bus.m_addr      = '0;
        bus.m_cmd       = '0;
        bus.m_wdata     = '0;
        bus.slave_ack   = 1'b0;
        bus.slave_rdata = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [M-1:0] rq;
        ack_prev = '0;
        if (owner < 0) begin
            for (int k = 1; k <= M; k++) begin
                int j = (last + k) % M;
                rq = bus.m_req >> j;
                if (rq[0]) begin
                    owner = j;
                    gidx  = j;
                    break;
                end
            end
        end else begin
            rq = bus.m_req >> owner;
            if (bus.slave_ack) ack_prev = M'(1) << owner;
            if (bus.slave_ack || !rq[0]) begin
                last  = owner;
                owner = -1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [M*N-1:0] sh;
        logic [M-1:0]   bits;
        logic [N-1:0]   ea, ew;
        logic           er, ec;
        #1;
        er = 1'b0; ec = 1'b0; ea = '0; ew = '0;
        if (owner >= 0) begin
            bits = bus.m_req >> owner;         er = bits[0];
            bits = bus.m_cmd >> owner;         ec = bits[0];
            sh   = bus.m_addr >> (owner * N);  ea = sh[N-1:0];
            sh   = bus.m_wdata >> (owner * N); ew = sh[N-1:0];
        end
        chk({tag, ".busy"},  N'(bus.busy),      N'(owner >= 0));
        chk({tag, ".gidx"},  N'(bus.grant_idx), N'(gidx));
        chk({tag, ".sreq"},  N'(bus.slave_req), N'(er));
        chk({tag, ".scmd"},  N'(bus.slave_cmd), N'(ec));
        chk({tag, ".saddr"}, bus.slave_addr,    ea);
        chk({tag, ".swdat"}, bus.slave_wdata,   ew);
        for (int i = 0; i < M; i++) begin
            bits = bus.m_ack >> i;
            chk($sformatf("%s.ack%0d", tag, i), N'(bits[0]), N'(owner == i && bus.slave_ack));
            sh = bus.m_rdata >> (i * N);
            chk($sformatf("%s.rdat%0d", tag, i), sh[N-1:0], (owner == i) ? bus.slave_rdata : '0);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic cycle(input string tag);
        check_outputs(tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        cycle("rst");
        cycle("rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [M-1:0]   bit_i;
        logic [M*N-1:0] fm;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // 1: single read from master 0, ack two cycles after grant
        do_reset();
        chk("t1.rst_gidx", N'(bus.grant_idx), '0);
        chk("t1.rst_busy", N'(bus.busy), '0);
        bus.m_req = 2'b01;
        bus.m_addr[31:0] = 32'h8000_0010;
        cycle("t1.arb");
        chk("t1.sreq_c1", N'(bus.slave_req), N'(1'b1));
        chk("t1.saddr", bus.slave_addr, 32'h8000_0010);
        cycle("t1.wait");
        bus.slave_ack = 1'b1;
        bus.slave_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1.mack", N'(bus.m_ack), N'(2'b01));
        chk("t1.rdata0", bus.m_rdata[31:0], 32'hDEAD_BEEF);
        chk("t1.rdata1", bus.m_rdata[63:32], '0);
        cycle("t1.ack");
        bus.slave_ack = 1'b0;
        bus.m_req = 2'b00;
        cycle("t1.done");
        chk("t1.mack_once", N'(bus.m_ack), '0);

        // 2: simultaneous requests, immediate ack
        do_reset();
        bus.m_req = 2'b11;
        bus.slave_ack = 1'b1;
        bus.slave_rdata = 32'h0000_1234;
        cycle("t2.arb0");
        chk("t2.g0", N'(bus.grant_idx), '0);
        cycle("t2.ack0");
        bus.m_req = 2'b10;
        cycle("t2.arb1");
        chk("t2.g1", N'(bus.grant_idx), N'(1));
        cycle("t2.ack1");

        // 3: both masters hold req for six transactions
        bus.m_req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            cycle("t3.idle");
            chk("t3.grant", N'(bus.grant_idx), N'(t % 2));
            chk("t3.busy", N'(bus.busy), N'(1'b1));
            cycle("t3.ack");
            chk("t3.gap", N'(bus.slave_req), '0);
        end
        clear_inputs();
        cycle("t3.end");

        // 4: master 1 locked, master 0 requests mid-transaction
        do_reset();
        bus.m_req = 2'b10;
        bus.m_addr = {32'h1111_2220, 32'h0000_0A00};
        cycle("t4.arb");
        bus.m_req = 2'b11;
        for (int t = 0; t < 5; t++) begin
            cycle("t4.hold");
            chk("t4.saddr", bus.slave_addr, 32'h1111_2220);
        end
        bus.slave_ack = 1'b1;
        cycle("t4.ack1");
        bus.m_req = 2'b01;
        bus.slave_ack = 1'b0;
        cycle("t4.arb0");
        chk("t4.next", N'(bus.grant_idx), '0);
        bus.slave_ack = 1'b1;
        cycle("t4.ack0");
        clear_inputs();
        cycle("t4.end");

        // 5: master 0 aborts, late ack is ignored
        do_reset();
        bus.m_req = 2'b01;
        cycle("t5.arb");
        cycle("t5.busy");
        bus.m_req = 2'b00;
        #1;
        chk("t5.sreq_drop", N'(bus.slave_req), '0);
        cycle("t5.abort");
        chk("t5.busy_next", N'(bus.busy), '0);
        bus.slave_ack = 1'b1;
        #1;
        chk("t5.late_ack", N'(bus.m_ack), '0);
        cycle("t5.late");
        bus.slave_ack = 1'b0;

        // 6: reset during an in-flight write from master 1
        do_reset();
        bus.m_req = 2'b01;
        cycle("t6.arb0");
        bus.slave_ack = 1'b1;
        cycle("t6.ack0");
        bus.slave_ack = 1'b0;
        bus.m_req = 2'b10;
        bus.m_cmd = 2'b10;
        bus.m_wdata[63:32] = 32'hA5A5_A5A5;
        cycle("t6.arb1");
        chk("t6.wdata", bus.slave_wdata, 32'hA5A5_A5A5);
        chk("t6.cmd", N'(bus.slave_cmd), N'(1'b1));
        #2;
        rst = 1'b1;
        bus.slave_ack = 1'b1;
        model_reset();
        #1;
        chk("t6.rst_sreq", N'(bus.slave_req), '0);
        chk("t6.rst_mack", N'(bus.m_ack), '0);
        chk("t6.rst_busy", N'(bus.busy), '0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        bus.m_req = 2'b11;
        cycle("t6.arb");
        chk("t6.prio0", N'(bus.grant_idx), '0);
        clear_inputs();
        cycle("t6.end");

        // Random traffic: masters mostly hold req until acked, occasional aborts and resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            for (int i = 0; i < M; i++) begin
                bit_i = M'(1) << i;
                fm    = (M*N)'({N{1'b1}}) << (i * N);
                if ((bus.m_req & bit_i) != '0) begin
                    if ((ack_prev & bit_i) != '0 ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0))
                        bus.m_req = bus.m_req & ~bit_i;
                end else if ($urandom_range(2) == 0) begin
                    bus.m_req   = bus.m_req | bit_i;
                    bus.m_cmd   = $urandom_range(1) == 0 ? (bus.m_cmd & ~bit_i) : (bus.m_cmd | bit_i);
                    bus.m_addr  = (bus.m_addr & ~fm) | ((M*N)'($urandom()) << (i * N));
                    bus.m_wdata = (bus.m_wdata & ~fm) | ((M*N)'($urandom()) << (i * N));
                end
            end
            bus.slave_ack   = ($urandom_range(2) == 0);
            bus.slave_rdata = $urandom();
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
